hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock, rising edge; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have ports: id_src1, id_src2  in  5 each  source registers of the instruction in ID; id_use_src2  in  1  ID instruction reads src2.
REQ-003 SHALL have ports: ex_mem_r_en, ex_wb_en  in  1 each  ID/EX register outputs; ex_dest  in  5  ID/EX destination; ex_br_taken  in  1  branch resolved taken in EX.
REQ-004 SHALL have ports: mem_r_en, mem_wb_en  in  1 each  EX/MEM controls; mem_dest  in  5  EX/MEM destination; mem_ready  in  1  data memory completes the read this cycle.
REQ-005 SHALL have ports: pc_write, if_id_write  out  1 each  fetch/decode advance enables; if_id_flush, id_exe_flush  out  1 each  bubble insert (id_exe_flush drives the ID/EX register flush input).
REQ-006 SHALL have ports: ex_mem_hold  out  1  freeze EX/MEM and later; fwd_a, fwd_b  out  2 each  ALU operand select (0 regfile, 1 EX/MEM, 2 MEM/WB); state  out  2  FSM state; stall_cnt  out  16  stall-cycle counter.

Function
REQ-007 SHALL implement FSM states RUN=0, LU_STALL=1, BR_FLUSH=2, MEM_WAIT=3.
REQ-008 RAW match SHALL require wb_en=1, dest!=0 and dest equal to the source; register 0 never matches.
REQ-009 Load-use SHALL be ex_mem_r_en & ex_dest matches id_src1, or id_src2 when id_use_src2=1.
REQ-010 Next-state priority SHALL be: mem_r_en & !mem_ready -> MEM_WAIT; else ex_br_taken -> BR_FLUSH; else load-use -> LU_STALL; else RUN.
REQ-011 Outputs SHALL be combinational from the current cycle's condition (same priority), zero-latency.
REQ-012 MEM_WAIT condition: pc_write=0, if_id_write=0, ex_mem_hold=1, no flush; held until mem_ready=1, exits to RUN in the following cycle.
REQ-013 Branch condition: if_id_flush=1, id_exe_flush=1, pc_write=1; a simultaneous load-use SHALL be ignored (flushed instruction).
REQ-014 Load-use condition: pc_write=0, if_id_write=0, id_exe_flush=1 for exactly one cycle; next cycle hazard re-evaluated.
REQ-015 Branch arriving while MEM_WAIT active SHALL be deferred until mem_ready; ex_br_taken is held stable by the frozen pipeline.
REQ-016 stall_cnt SHALL increment by 1 in every cycle with pc_write=0, saturating at 0xFFFF.
REQ-017 Forward select SHALL prefer EX/MEM match (1) over MEM/WB match (2), else 0; MEM/WB stage inputs are ex_mem_hold-delayed copies of mem_dest/mem_wb_en registered inside the block.

Reset
REQ-018 On rst=1 at clk edge: state=RUN, stall_cnt=0, internal MEM/WB copies cleared (wb_en=0).
REQ-019 During rst=1 outputs SHALL be pc_write=1, if_id_write=1, flushes=1, ex_mem_hold=0, fwd_a=fwd_b=0.
REQ-020 Reset asserted mid MEM_WAIT SHALL abort the wait; no pending hazard survives reset.

Configuration
REQ-021 Macro HAZARD_FWD_EN defined: forwarding per REQ-017.
REQ-022 Macro undefined: fwd_a=fwd_b=0 constantly; any RAW match against EX (ex_wb_en) or EX/MEM (mem_wb_en) SHALL be treated as load-use stall (REQ-014 behaviour), repeating until clear.

Structure
REQ-023 State encodings, fwd select encodings and stall_cnt width SHALL live in shared package pipe_pkg.
REQ-024 The RAW comparator SHALL be a sub-module raw_match (dest, wb_en, src -> hit), instantiated per source/stage pair.

Verification
REQ-025 ex_mem_r_en=1, ex_dest=5, id_src1=5 -> one cycle pc_write=0, id_exe_flush=1, state=LU_STALL, stall_cnt=1.
REQ-026 ex_br_taken=1 plus load-use on r5 same cycle -> if_id_flush=id_exe_flush=1, pc_write=1, state=BR_FLUSH, stall_cnt unchanged.
REQ-027 mem_r_en=1, mem_ready=0 for 3 cycles then 1 -> ex_mem_hold=1 for 3 cycles, stall_cnt=3, then RUN.
REQ-028 ex_wb_en=1, ex_dest=0, id_src1=0 -> no stall, fwd_a=0.
REQ-029 With HAZARD_FWD_EN: mem_wb_en=1, mem_dest=7, id_src2=7, id_use_src2=1 -> fwd_b=1; without macro -> stall, fwd_b=0.
REQ-030 rst=1 during MEM_WAIT -> next cycle state=RUN, stall_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states,
// forward-select codes and counter/register widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        BR_FLUSH = 2'd2,
        MEM_WAIT = 2'd3
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    localparam int unsigned STALL_CNT_W = 16;
    localparam int unsigned REG_W       = 5;

endpackage

// File: rtl/raw_match.sv
// Read-after-write comparator: a pending write to a non-zero register
// whose destination equals the source being read.
module raw_match
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] dest,
    input  logic             wb_en,
    input  logic [REG_W-1:0] src,
    output logic             hit
);

    assign hit = wb_en && (dest != '0) && (dest == src);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, memory-wait freeze and operand
// forwarding. Define HAZARD_FWD_EN to enable forwarding; otherwise RAW hazards stall.
module hazard_ctrl
    import pipe_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_W-1:0]       id_src1,
    input  logic [REG_W-1:0]       id_src2,
    input  logic                   id_use_src2,
    input  logic                   ex_mem_r_en,
    input  logic                   ex_wb_en,
    input  logic [REG_W-1:0]       ex_dest,
    input  logic                   ex_br_taken,
    input  logic                   mem_r_en,
    input  logic                   mem_wb_en,
    input  logic [REG_W-1:0]       mem_dest,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic                   id_exe_flush,
    output logic                   ex_mem_hold,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic [1:0]             state,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    hz_state_t cur_state, next_state, cond;
    logic      lu_hit1, lu_hit2, em_hit1, em_hit2;
    logic      load_use;

    // A load in EX writes its destination, so its read enable acts as wb_en.
    raw_match u_lu1 (.dest(ex_dest),  .wb_en(ex_mem_r_en), .src(id_src1), .hit(lu_hit1));
    raw_match u_lu2 (.dest(ex_dest),  .wb_en(ex_mem_r_en), .src(id_src2), .hit(lu_hit2));
    raw_match u_em1 (.dest(mem_dest), .wb_en(mem_wb_en),   .src(id_src1), .hit(em_hit1));
    raw_match u_em2 (.dest(mem_dest), .wb_en(mem_wb_en),   .src(id_src2), .hit(em_hit2));

`ifdef HAZARD_FWD_EN
    logic [REG_W-1:0] wb_dest;
    logic             wb_en_q;
    logic             wb_hit1, wb_hit2;
    logic             unused_ex_wb_en;
    fwd_sel_t         sel_a, sel_b;

    assign unused_ex_wb_en = ex_wb_en;
    assign load_use = lu_hit1 | (id_use_src2 & lu_hit2);

    raw_match u_wb1 (.dest(wb_dest), .wb_en(wb_en_q), .src(id_src1), .hit(wb_hit1));
    raw_match u_wb2 (.dest(wb_dest), .wb_en(wb_en_q), .src(id_src2), .hit(wb_hit2));

    // MEM/WB copy freezes with the rest of the back end during a memory wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_dest <= '0;
            wb_en_q <= 1'b0;
        end else if (!ex_mem_hold) begin
            wb_dest <= mem_dest;
            wb_en_q <= mem_wb_en;
        end
    end

    always_comb begin
        sel_a = FWD_RF;
        sel_b = FWD_RF;
        if (!rst) begin
            if (em_hit1)      sel_a = FWD_EXMEM;
            else if (wb_hit1) sel_a = FWD_MEMWB;
            if (em_hit2)      sel_b = FWD_EXMEM;
            else if (wb_hit2) sel_b = FWD_MEMWB;
        end
    end

    assign fwd_a = sel_a;
    assign fwd_b = sel_b;
`else
    logic ex_hit1, ex_hit2;

    raw_match u_ex1 (.dest(ex_dest), .wb_en(ex_wb_en), .src(id_src1), .hit(ex_hit1));
    raw_match u_ex2 (.dest(ex_dest), .wb_en(ex_wb_en), .src(id_src2), .hit(ex_hit2));

    // Without forwarding every in-flight RAW dependency stalls like a load-use.
    assign load_use = lu_hit1 | ex_hit1 | em_hit1
                    | (id_use_src2 & (lu_hit2 | ex_hit2 | em_hit2));

    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

    always_comb begin
        cond = RUN;
        if (mem_r_en && !mem_ready) cond = MEM_WAIT;
        else if (ex_br_taken)       cond = BR_FLUSH;
        else if (load_use)          cond = LU_STALL;

        next_state   = cond;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_exe_flush = 1'b0;
        ex_mem_hold  = 1'b0;

        if (rst) begin
            next_state   = RUN;
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
        end else begin
            case (cond)
                MEM_WAIT: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    ex_mem_hold = 1'b1;
                end
                BR_FLUSH: begin
                    if_id_flush  = 1'b1;
                    id_exe_flush = 1'b1;
                end
                LU_STALL: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_exe_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cur_state <= RUN;
        else     cur_state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (!pc_write && (stall_cnt != '1))
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end

    assign state = cur_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_src1, id_src2, ex_dest, mem_dest;
    logic        id_use_src2, ex_mem_r_en, ex_wb_en, ex_br_taken;
    logic        mem_r_en, mem_wb_en, mem_ready;
    logic        pc_write, if_id_write, if_id_flush, id_exe_flush, ex_mem_hold;
    logic [1:0]  fwd_a, fwd_b, state;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_err    = 0;

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_use_src2(id_use_src2),
        .ex_mem_r_en(ex_mem_r_en), .ex_wb_en(ex_wb_en), .ex_dest(ex_dest),
        .ex_br_taken(ex_br_taken),
        .mem_r_en(mem_r_en), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
        .ex_mem_hold(ex_mem_hold), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .state(state), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pipeline bookkeeping and expected outputs.
    int m_state = 0, m_cnt = 0, m_wb_dest = 0;
    bit m_wb_en = 0;
    int e_pw, e_iw, e_iff, e_ef, e_hold, e_fa, e_fb, e_cond;

    function automatic bit raw(input bit en, input int dest, input int src);
        return en && dest != 0 && dest == src;
    endfunction

    function void eval_model();
        bit lu;
        int s1, s2;
        s1 = id_src1;
        s2 = id_src2;
        lu = raw(ex_mem_r_en, ex_dest, s1) || (id_use_src2 && raw(ex_mem_r_en, ex_dest, s2));
`ifndef HAZARD_FWD_EN
        lu = lu || raw(ex_wb_en, ex_dest, s1) || raw(mem_wb_en, mem_dest, s1)
                || (id_use_src2 && (raw(ex_wb_en, ex_dest, s2) || raw(mem_wb_en, mem_dest, s2)));
`endif
        if (mem_r_en && !mem_ready) e_cond = 3;
        else if (ex_br_taken)       e_cond = 2;
        else if (lu)                e_cond = 1;
        else                        e_cond = 0;
        e_fa = 0;
        e_fb = 0;
        if (rst) begin
            e_cond = 0;
            e_pw = 1; e_iw = 1; e_iff = 1; e_ef = 1; e_hold = 0;
        end else begin
            e_pw   = (e_cond == 0 || e_cond == 2) ? 1 : 0;
            e_iw   = e_pw;
            e_iff  = (e_cond == 2) ? 1 : 0;
            e_ef   = (e_cond == 1 || e_cond == 2) ? 1 : 0;
            e_hold = (e_cond == 3) ? 1 : 0;
`ifdef HAZARD_FWD_EN
            e_fa = raw(mem_wb_en, mem_dest, s1) ? 1 : raw(m_wb_en, m_wb_dest, s1) ? 2 : 0;
            e_fb = raw(mem_wb_en, mem_dest, s2) ? 1 : raw(m_wb_en, m_wb_dest, s2) ? 2 : 0;
`endif
        end
    endfunction

    // Single compare process: check at negedge, advance the model at posedge.
    initial begin
        forever begin
            @(negedge clk);
            eval_model();
            check("pc_write",     pc_write,     e_pw);
            check("if_id_write",  if_id_write,  e_iw);
            check("if_id_flush",  if_id_flush,  e_iff);
            check("id_exe_flush", id_exe_flush, e_ef);
            check("ex_mem_hold",  ex_mem_hold,  e_hold);
            check("fwd_a",        fwd_a,        e_fa);
            check("fwd_b",        fwd_b,        e_fb);
            check("state",        state,        m_state);
            check("stall_cnt",    stall_cnt,    m_cnt);
            @(posedge clk);
            if (rst) begin
                m_state = 0; m_cnt = 0; m_wb_en = 0; m_wb_dest = 0;
            end else begin
                m_state = e_cond;
                if (e_pw == 0 && m_cnt < 65535) m_cnt++;
                if (e_hold == 0) begin
                    m_wb_en   = mem_wb_en;
                    m_wb_dest = mem_dest;
                end
            end
        end
    end

    task automatic idle();
        id_src1 = 0; id_src2 = 0; id_use_src2 = 0;
        ex_mem_r_en = 0; ex_wb_en = 0; ex_dest = 0; ex_br_taken = 0;
        mem_r_en = 0; mem_wb_en = 0; mem_dest = 0; mem_ready = 1;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        idle();
        next_cyc();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        #3;
        check("rst_pc_write",  pc_write,     1);
        check("rst_if_flush",  if_id_flush,  1);
        check("rst_ex_flush",  id_exe_flush, 1);
        check("rst_hold",      ex_mem_hold,  0);
        next_cyc();
        check("rst_state", state, 0);
        check("rst_cnt",   stall_cnt, 0);
        rst = 0;

        // Load-use on r5.
        ex_mem_r_en = 1; ex_dest = 5; id_src1 = 5;
        #3;
        check("lu_pc_write", pc_write, 0);
        check("lu_ex_flush", id_exe_flush, 1);
        next_cyc();
        check("lu_state", state, 1);
        check("lu_cnt",   stall_cnt, 1);
        idle();
        #3;
        check("lu_release", pc_write, 1);

        // Branch with simultaneous load-use: branch wins.
        next_cyc();
        ex_br_taken = 1; ex_mem_r_en = 1; ex_dest = 5; id_src1 = 5;
        #3;
        check("br_if_flush",  if_id_flush, 1);
        check("br_ex_flush",  id_exe_flush, 1);
        check("br_pc_write",  pc_write, 1);
        next_cyc();
        check("br_state", state, 2);
        check("br_cnt",   stall_cnt, 1);

        // Register 0 never matches.
        idle();
        ex_wb_en = 1; ex_dest = 0; id_src1 = 0;
        #3;
        check("r0_pc_write", pc_write, 1);
        check("r0_fwd_a",    fwd_a, 0);
        next_cyc();

        // Three-cycle memory wait.
        do_reset();
        mem_r_en = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #3;
            check("mw_hold", ex_mem_hold, 1);
            next_cyc();
        end
        check("mw_state", state, 3);
        check("mw_cnt",   stall_cnt, 3);
        mem_ready = 1;
        #3;
        check("mw_release", ex_mem_hold, 0);
        next_cyc();
        check("mw_exit_state", state, 0);
        idle();

        // Reset aborts a memory wait.
        mem_r_en = 1; mem_ready = 0;
        next_cyc();
        next_cyc();
        rst = 1;
        #3;
        check("rstmw_hold", ex_mem_hold, 0);
        next_cyc();
        check("rstmw_state", state, 0);
        check("rstmw_cnt",   stall_cnt, 0);
        rst = 0;
        idle();

        // EX/MEM dependency on src2.
        mem_wb_en = 1; mem_dest = 7; id_src2 = 7; id_use_src2 = 1;
        #3;
`ifdef HAZARD_FWD_EN
        check("fwd_b_exmem", fwd_b, 1);
        check("fwd_pc_write", pc_write, 1);
`else
        check("nofwd_b", fwd_b, 0);
        check("nofwd_pc_write", pc_write, 0);
        next_cyc();
        check("nofwd_state", state, 1);
`endif
        next_cyc();
        idle();

        // Randomized traffic; small register range makes matches frequent.
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 63) == 0);
            id_src1     = 5'($urandom_range(0, 3));
            id_src2     = 5'($urandom_range(0, 3));
            id_use_src2 = 1'($urandom);
            ex_mem_r_en = ($urandom_range(0, 3) == 0);
            ex_wb_en    = 1'($urandom);
            ex_dest     = 5'($urandom_range(0, 3));
            ex_br_taken = ($urandom_range(0, 5) == 0);
            mem_r_en    = ($urandom_range(0, 2) == 0);
            mem_wb_en   = 1'($urandom);
            mem_dest    = 5'($urandom_range(0, 3));
            mem_ready   = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 9) == 0) id_src1 = 5'($urandom);
            next_cyc();
        end
        rst = 0;
        idle();
        next_cyc();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
